fast_square_sweep_ctrl: RTL and testbench
=========================================

Name: fast_square_sweep_ctrl

Overview:
- Sequencer directly upstream of fast_square_rx; drives its reset, record, freq_step and data_out_strobe inputs.
- Runs a stepped-frequency sweep as repeated settle -> record window -> freq_step -> drain of the 2*NUM_SUBCARRIERS+1 result words.
- Configured through the serial settings bus; drain pacing follows a host-FIFO ready signal.

Parameters:
- CTRLADDR, 3: serial settings address of the control word.
- RECORD_TICKS_LOG2, 14: record window length is 2^RECORD_TICKS_LOG2 cycles; must match fast_square_rx.
- NUM_SUBCARRIERS, 4: words drained per step = 2*NUM_SUBCARRIERS+1.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- serial_addr  in  7  settings bus address.
- serial_data  in  32  settings bus data.
- serial_strobe  in  1  settings bus write strobe.
- fifo_ready  in  1  downstream host FIFO can take a word this cycle.
- rx_reset  out  1  one-cycle pulse; reloads fast_square_rx frequency settings.
- record  out  1  record window active.
- freq_step  out  1  one-cycle step pulse.
- data_out_strobe  out  1  read strobe to fast_square_rx; consumer captures i_out/q_out in this cycle.
- busy  out  1  high in any state except IDLE.
- sweep_done  out  1  one-cycle pulse when the last drain of a sweep completes.
- step_idx  out  8  index of the current step, 0-based.

Behaviour:
- Control word fields, registered on serial_strobe && serial_addr==CTRLADDR:
  - [7:0] num_steps; value 0 means 256.
  - [23:8] settle_ticks.
  - [29] abort.
  - [30] continuous.
  - [31] start. Start and abort are self-clearing pulses, not stored.
- Reset: state IDLE; all outputs 0; step_idx 0; counters 0.
- IDLE: on start go to INIT. A start seen in any other state is ignored.
- INIT (1 cycle): rx_reset=1; step_idx<=0; load settle counter -> SETTLE.
- SETTLE: record=0; count settle_ticks cycles. settle_ticks==0 takes exactly 1 cycle. Covers CORDIC pipeline flush. Then go to RECORD.
- RECORD: record=1 for exactly 2^RECORD_TICKS_LOG2 consecutive cycles -> STEP.
- STEP (1 cycle): record=0, freq_step=1 -> DRAIN.
- DRAIN: data_out_strobe=fifo_ready, one word per cycle. Exit after exactly 2*NUM_SUBCARRIERS+1 strobes. fifo_ready low stalls with no strobe.
- Leaving DRAIN:
  - If step_idx==num_steps-1 (mod 256): pulse sweep_done, then go to INIT if continuous, else IDLE.
  - Otherwise step_idx+1 -> SETTLE.
- Timing rules:
  - freq_step is never asserted in the same cycle as record or data_out_strobe.
  - record never overlaps rx_reset.
- Abort: takes effect in the cycle after the write, from any state, and wins over every other transition. All outputs go to 0 and state goes to IDLE. No sweep_done. A partially drained step is discarded.
- Simultaneous start+abort in IDLE: abort wins, stay in IDLE.
- Settings rewritten mid-sweep: num_steps, settle_ticks and continuous take effect at the next evaluation. The running counter is not reloaded.
- Counters: 16-bit settle down-counter; RECORD_TICKS_LOG2+1-bit record counter; 4-bit drain counter; no wrap inside a state.
- reset_n assertion mid-operation: immediate asynchronous return to the reset state.

Optional Feature:
- Macro: FAST_SQUARE_DRAIN_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts consecutive DRAIN cycles with fifo_ready=0.
  - At 65535 the block behaves as an abort and sets sticky output drain_timeout (1 bit).
  - drain_timeout clears on the next start.
- Undefined: DRAIN waits indefinitely; no drain_timeout port.

Decomposition:
- Package fsq_sweep_pkg holds:
  - state encoding IDLE/INIT/SETTLE/RECORD/STEP/DRAIN;
  - control-word field bit positions;
  - WORDS_PER_STEP = 2*NUM_SUBCARRIERS+1;
  - timeout limit.
- One sub-module, fsq_tick_counter: loadable down-counter with load, enable and zero flag. Instanced for settle, record and drain.

Test Plan:
- Write start, num_steps=2, settle=4, RECORD_TICKS_LOG2=4, fifo_ready=1:
  - rx_reset pulse, then 4 cycles idle, then 16 record cycles, then freq_step, then 9 consecutive strobes;
  - repeated once with step_idx=1;
  - sweep_done once; back to IDLE.
- Same run with fifo_ready toggling 1/0 in DRAIN -> exactly 9 strobes, each only in a fifo_ready=1 cycle; no record during DRAIN.
- Abort written in the 8th RECORD cycle -> record=0 next cycle, no freq_step, no sweep_done, busy=0.
- continuous=1, num_steps=1 -> INIT re-entered after each drain; rx_reset every sweep; sweep_done every sweep.
- num_steps=0 -> 256 steps; step_idx goes 0..255; single sweep_done.
- With FAST_SQUARE_DRAIN_TIMEOUT_EN and fifo_ready held 0 -> after 65535 stalled cycles: drain_timeout=1, IDLE; next start clears drain_timeout.

Source files
------------

// File: rtl/fsq_sweep_pkg.sv
// fsq_sweep_pkg: shared types and constants for the
// fast_square_rx sweep sequencer.
package fsq_sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SETTLE,
    S_RECORD,
    S_STEP,
    S_DRAIN
  } state_t;

  localparam int NSTEP_LSB  = 0;
  localparam int NSTEP_W    = 8;
  localparam int SETTLE_LSB = 8;
  localparam int SETTLE_W   = 16;
  localparam int ABORT_BIT  = 29;
  localparam int CONT_BIT   = 30;
  localparam int START_BIT  = 31;

  localparam int NSUB_DEF = 4;

  function automatic int words_per_step(input int nsub);
    return 2 * nsub + 1;
  endfunction

  localparam int WORDS_PER_STEP = words_per_step(NSUB_DEF);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

endpackage

// File: rtl/fsq_sweep_if.sv
// fsq_sweep_if: serial settings bus carrying the
// sequencer control word.
interface fsq_sweep_if;

  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;

  modport master (
    output serial_addr,
    output serial_data,
    output serial_strobe
  );

  modport slave (
    input serial_addr,
    input serial_data,
    input serial_strobe
  );

endinterface

// File: rtl/fsq_tick_counter.sv
// fsq_tick_counter: loadable down-counter with enable
// and zero flag; holds at zero instead of wrapping.
module fsq_tick_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // load has priority; count down only while non-zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fast_square_sweep_ctrl.sv
// fast_square_sweep_ctrl: stepped-frequency sweep sequencer for fast_square_rx.
// Optional drain watchdog enabled by FAST_SQUARE_DRAIN_TIMEOUT_EN.
module fast_square_sweep_ctrl
  import fsq_sweep_pkg::*;
#(
  parameter int CTRLADDR          = 3,
  parameter int RECORD_TICKS_LOG2 = 14,
  parameter int NUM_SUBCARRIERS   = NSUB_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  fsq_sweep_if.slave sbus,
  input  logic       fifo_ready,
  output logic       rx_reset,
  output logic       record,
  output logic       freq_step,
  output logic       data_out_strobe,
  output logic       busy,
  output logic       sweep_done,
  output logic [7:0] step_idx
`ifdef FAST_SQUARE_DRAIN_TIMEOUT_EN
  ,
  output logic       drain_timeout
`endif
);

  localparam int RW = RECORD_TICKS_LOG2 + 1;
  localparam logic [RW-1:0] REC_LOAD =
    RW'((1 << RECORD_TICKS_LOG2) - 1);
  localparam logic [3:0] DRN_LOAD =
    4'(words_per_step(NUM_SUBCARRIERS) - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_nsteps;
  logic [15:0] r_settle;
  logic        r_cont;
  logic [7:0]  r_step_idx;
  logic        r_sweep_done;

  logic        w_wr;
  logic        w_start;
  logic        w_abort;
  logic        w_kill;
  logic        w_last;
  logic        w_done;
  logic        w_step_inc;
  logic        w_step_clr;
  logic        w_set_ld;
  logic        w_set_en;
  logic        w_set_z;
  logic        w_rec_ld;
  logic        w_rec_en;
  logic        w_rec_z;
  logic        w_drn_ld;
  logic        w_drn_en;
  logic        w_drn_z;
  logic [15:0] w_set_val;
  logic        w_unused;

  assign w_wr = sbus.serial_strobe &&
                (sbus.serial_addr == 7'(CTRLADDR));
  assign w_start = w_wr && sbus.serial_data[START_BIT];
  assign w_abort = w_wr && sbus.serial_data[ABORT_BIT];
  assign w_unused = ^sbus.serial_data[28:24];

  assign w_last = (r_step_idx == r_nsteps - 8'd1);
  assign w_set_val = r_settle -
                     {15'd0, (r_settle != 16'd0)};

`ifdef FAST_SQUARE_DRAIN_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_drain_timeout;
  logic        w_tmo;

  assign w_tmo = (r_state == S_DRAIN) &&
                 (r_wdog == TIMEOUT_LIMIT);
  assign w_kill = w_abort || w_tmo;
  assign drain_timeout = r_drain_timeout;

  // count consecutive stalled drain cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else if ((r_state == S_DRAIN) && !fifo_ready) begin
      r_wdog <= r_wdog + 16'd1;
    end else begin
      r_wdog <= '0;
    end
  end

  // sticky timeout flag, cleared by an accepted start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_drain_timeout <= 1'b0;
    end else if (w_tmo) begin
      r_drain_timeout <= 1'b1;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_drain_timeout <= 1'b0;
    end
  end
`else
  assign w_kill = w_abort;
`endif

  fsq_tick_counter #(.W(16)) u_settle (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_set_ld),
    .i_en    (w_set_en),
    .i_val   (w_set_val),
    .o_zero  (w_set_z)
  );

  fsq_tick_counter #(.W(RW)) u_record (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_rec_ld),
    .i_en    (w_rec_en),
    .i_val   (REC_LOAD),
    .o_zero  (w_rec_z)
  );

  fsq_tick_counter #(.W(4)) u_drain (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_drn_ld),
    .i_en    (w_drn_en),
    .i_val   (DRN_LOAD),
    .o_zero  (w_drn_z)
  );

  // control word fields; start/abort are not stored
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_nsteps <= '0;
      r_settle <= '0;
      r_cont   <= 1'b0;
    end else if (w_wr) begin
      r_nsteps <= sbus.serial_data[NSTEP_LSB +: NSTEP_W];
      r_settle <= sbus.serial_data[SETTLE_LSB +: SETTLE_W];
      r_cont   <= sbus.serial_data[CONT_BIT];
    end
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // step index and end-of-sweep pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_step_idx   <= '0;
      r_sweep_done <= 1'b0;
    end else begin
      r_sweep_done <= w_done;
      if (w_step_clr) begin
        r_step_idx <= '0;
      end else if (w_step_inc) begin
        r_step_idx <= r_step_idx + 8'd1;
      end
    end
  end

  // next state, strobes and counter controls
  always_comb begin
    w_next          = r_state;
    rx_reset        = 1'b0;
    record          = 1'b0;
    freq_step       = 1'b0;
    data_out_strobe = 1'b0;
    w_done          = 1'b0;
    w_step_inc      = 1'b0;
    w_step_clr      = 1'b0;
    w_set_ld        = 1'b0;
    w_set_en        = 1'b0;
    w_rec_ld        = 1'b0;
    w_rec_en        = 1'b0;
    w_drn_ld        = 1'b0;
    w_drn_en        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_INIT;
      end
      S_INIT: begin
        rx_reset   = 1'b1;
        w_step_clr = 1'b1;
        w_set_ld   = 1'b1;
        w_next     = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_set_z) begin
          w_rec_ld = 1'b1;
          w_next   = S_RECORD;
        end else begin
          w_set_en = 1'b1;
        end
      end
      S_RECORD: begin
        record = 1'b1;
        if (w_rec_z) w_next = S_STEP;
        else         w_rec_en = 1'b1;
      end
      S_STEP: begin
        freq_step = 1'b1;
        w_drn_ld  = 1'b1;
        w_next    = S_DRAIN;
      end
      S_DRAIN: begin
        data_out_strobe = fifo_ready;
        if (fifo_ready && w_drn_z) begin
          if (w_last) begin
            w_done = 1'b1;
            w_next = r_cont ? S_INIT : S_IDLE;
          end else begin
            w_step_inc = 1'b1;
            w_set_ld   = 1'b1;
            w_next     = S_SETTLE;
          end
        end else if (fifo_ready) begin
          w_drn_en = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_kill) begin
      w_next     = S_IDLE;
      w_done     = 1'b0;
      w_step_inc = 1'b0;
      w_step_clr = 1'b1;
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign sweep_done = r_sweep_done;
  assign step_idx   = r_step_idx;

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// tb_fast_square_sweep_ctrl: event scoreboard bench
// for the sweep sequencer (RECORD_TICKS_LOG2=4).
module tb_fast_square_sweep_ctrl;

  localparam int RLEN  = 16;
  localparam int WORDS = 9;

  localparam int EV_RXRST = 0;
  localparam int EV_REC   = 1;
  localparam int EV_STEP  = 2;
  localparam int EV_STB   = 3;
  localparam int EV_DONE  = 4;

  typedef struct {
    int kind;
    int len;
    int gap;
    int step;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t e_obs;
  ev_t e_exp;

  int total = 0;
  int bad   = 0;
  int fr_mode = 0;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       fifo_ready = 1'b1;
  logic       rx_reset;
  logic       record;
  logic       freq_step;
  logic       data_out_strobe;
  logic       busy;
  logic       sweep_done;
  logic [7:0] step_idx;
`ifdef FAST_SQUARE_DRAIN_TIMEOUT_EN
  logic       drain_timeout;
`endif

  fsq_sweep_if sbus();

  fast_square_sweep_ctrl #(
    .CTRLADDR          (3),
    .RECORD_TICKS_LOG2 (4),
    .NUM_SUBCARRIERS   (4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .sbus            (sbus),
    .fifo_ready      (fifo_ready),
    .rx_reset        (rx_reset),
    .record          (record),
    .freq_step       (freq_step),
    .data_out_strobe (data_out_strobe),
    .busy            (busy),
    .sweep_done      (sweep_done),
    .step_idx        (step_idx)
`ifdef FAST_SQUARE_DRAIN_TIMEOUT_EN
    ,
    .drain_timeout   (drain_timeout)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: run did not finish, required finish");
    $fatal(1, "global timeout");
  end

  // fifo_ready pattern: 0 = always ready, 1 = toggle, 2 = held low
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (fr_mode)
        0:       fifo_ready = 1'b1;
        1:       fifo_ready = ~fifo_ready;
        default: fifo_ready = 1'b0;
      endcase
    end
  end

  int gap = 0;
  int rec_len = 0;
  int rec_gap = 0;
  int rec_step = 0;
  bit in_rec = 1'b0;
  bit evt;

  // compress outputs into events and score them against exp_q
  always @(negedge clock) begin
    if (!reset_n) begin
      in_rec = 1'b0;
      gap = 0;
    end else begin
      evt = 1'b0;
      obs_q.delete();
      if (sweep_done) begin
        obs_q.push_back('{EV_DONE, 0, gap, int'(step_idx)});
        evt = 1'b1;
      end
      if (rx_reset) begin
        obs_q.push_back('{EV_RXRST, 0, gap, int'(step_idx)});
        evt = 1'b1;
      end
      if (record) begin
        if (!in_rec) begin
          in_rec = 1'b1;
          rec_len = 0;
          rec_gap = gap;
          rec_step = int'(step_idx);
        end
        rec_len++;
        evt = 1'b1;
      end else if (in_rec) begin
        in_rec = 1'b0;
        obs_q.push_back('{EV_REC, rec_len, rec_gap, rec_step});
      end
      if (freq_step) begin
        obs_q.push_back('{EV_STEP, 0, gap, int'(step_idx)});
        evt = 1'b1;
      end
      if (data_out_strobe) begin
        obs_q.push_back('{EV_STB, 0, gap, int'(step_idx)});
        evt = 1'b1;
        total++;
        if (fifo_ready !== 1'b1) begin
          bad++;
          $display("FAIL strobe_ready: fifo_ready=%b at strobe, required 1", fifo_ready);
        end
      end
      total++;
      if ((freq_step && (record || data_out_strobe)) ||
          (record && (rx_reset || data_out_strobe))) begin
        bad++;
        $display("FAIL overlap: rst=%b rec=%b step=%b stb=%b, required disjoint",
                 rx_reset, record, freq_step, data_out_strobe);
      end
      if (evt) gap = 0;
      else if (busy) gap++;
      while (obs_q.size() > 0) begin
        e_obs = obs_q.pop_front();
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: kind=%0d len=%0d step=%0d, required none",
                   e_obs.kind, e_obs.len, e_obs.step);
        end else begin
          e_exp = exp_q.pop_front();
          if (e_obs.kind !== e_exp.kind || e_obs.len !== e_exp.len ||
              (e_exp.gap >= 0 && e_obs.gap !== e_exp.gap) ||
              (e_exp.step >= 0 && e_obs.step !== e_exp.step)) begin
            bad++;
            $display("FAIL event: got kind=%0d len=%0d gap=%0d step=%0d, required kind=%0d len=%0d gap=%0d step=%0d",
                     e_obs.kind, e_obs.len, e_obs.gap, e_obs.step,
                     e_exp.kind, e_exp.len, e_exp.gap, e_exp.step);
          end
        end
      end
    end
  end

  function automatic logic [31:0] cw(input bit st, input bit ab, input bit co,
                                     input logic [15:0] settle,
                                     input logic [7:0] n);
    return {st, co, ab, 5'd0, settle, n};
  endfunction

  task automatic push_ev(input int k, input int l, input int g, input int s);
    exp_q.push_back('{k, l, g, s});
  endtask

  task automatic push_steps(input int n, input int sgap, input int bgap);
    for (int s = 0; s < n; s++) begin
      push_ev(EV_REC, RLEN, sgap, s);
      push_ev(EV_STEP, 0, -1, s);
      for (int w = 0; w < WORDS; w++) push_ev(EV_STB, 0, bgap, s);
    end
  endtask

  task automatic wr(input logic [31:0] d, input logic [6:0] a);
    sbus.serial_addr   = a;
    sbus.serial_data   = d;
    sbus.serial_strobe = 1'b1;
    @(posedge clock);
    #1;
    sbus.serial_strobe = 1'b0;
    sbus.serial_data   = '0;
  endtask

  task automatic wait_empty(input int limit, input bit need_idle);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && (!need_idle || busy === 1'b0)) break;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_record(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (record === 1'b1) break;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({rx_reset, record, freq_step, data_out_strobe, busy, sweep_done} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {rx_reset, record, freq_step, data_out_strobe, busy, sweep_done});
    end
    total++;
    if (step_idx !== 8'd0) begin
      bad++;
      $display("FAIL reset_step_idx: got %0d, required 0", step_idx);
    end
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic;
    fr_mode = 0;
    push_ev(EV_RXRST, 0, -1, -1);
    push_steps(2, 4, 0);
    push_ev(EV_DONE, 0, -1, 1);
    wr(cw(1, 0, 0, 16'd4, 8'd2), 7'd3);
    total++;
    if (busy !== 1'b1 || rx_reset !== 1'b1) begin
      bad++;
      $display("FAIL basic_init: busy=%b rx_reset=%b, required 1 1", busy, rx_reset);
    end
    wait_record(50);
    wr(cw(1, 0, 0, 16'd4, 8'd2), 7'd3);
    wait_empty(2000, 1'b1);
    total++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_end: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
      exp_q.delete();
    end
    total++;
    if (step_idx !== 8'd1) begin
      bad++;
      $display("FAIL basic_step_idx: got %0d, required 1", step_idx);
    end
  endtask

  task automatic test_fifo_toggle;
    fr_mode = 1;
    push_ev(EV_RXRST, 0, -1, -1);
    push_steps(2, 4, -1);
    push_ev(EV_DONE, 0, -1, 1);
    wr(cw(1, 0, 0, 16'd4, 8'd2), 7'd3);
    wait_empty(2000, 1'b1);
    total++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL toggle_end: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
      exp_q.delete();
    end
    fr_mode = 0;
  endtask

  task automatic test_abort;
    fr_mode = 0;
    push_ev(EV_RXRST, 0, -1, -1);
    push_ev(EV_REC, 8, 4, 0);
    wr(cw(1, 0, 0, 16'd4, 8'd2), 7'd3);
    wait_record(50);
    repeat (7) begin
      @(posedge clock);
      #1;
    end
    wr(cw(0, 1, 0, 16'd4, 8'd2), 7'd3);
    total++;
    if (record !== 1'b0 || busy !== 1'b0 || freq_step !== 1'b0) begin
      bad++;
      $display("FAIL abort_next: record=%b busy=%b freq_step=%b, required 0 0 0",
               record, busy, freq_step);
    end
    repeat (40) begin
      @(posedge clock);
      #1;
    end
    total++;
    if (exp_q.size() != 0 || step_idx !== 8'd0) begin
      bad++;
      $display("FAIL abort_end: pending=%0d step_idx=%0d, required 0 0", exp_q.size(), step_idx);
      exp_q.delete();
    end
  endtask

  task automatic test_continuous;
    fr_mode = 0;
    for (int k = 0; k < 3; k++) begin
      push_ev(EV_RXRST, 0, -1, -1);
      push_steps(1, 2, 0);
      push_ev(EV_DONE, 0, -1, 0);
    end
    push_ev(EV_RXRST, 0, -1, -1);
    wr(cw(1, 0, 1, 16'd2, 8'd1), 7'd3);
    wait_empty(1000, 1'b0);
    total++;
    if (exp_q.size() != 0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL cont_sweeps: pending=%0d busy=%b, required 0 1", exp_q.size(), busy);
      exp_q.delete();
    end
    wr(cw(0, 1, 0, 16'd2, 8'd1), 7'd3);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL cont_abort: busy=%b, required 0", busy);
    end
    repeat (30) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_num_steps_zero;
    fr_mode = 0;
    push_ev(EV_RXRST, 0, -1, -1);
    push_steps(256, 1, 0);
    push_ev(EV_DONE, 0, -1, 255);
    wr(cw(1, 0, 0, 16'd0, 8'd0), 7'd3);
    wait_empty(10000, 1'b1);
    total++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL n256_end: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
      exp_q.delete();
    end
    total++;
    if (step_idx !== 8'd255) begin
      bad++;
      $display("FAIL n256_step_idx: got %0d, required 255", step_idx);
    end
  endtask

  task automatic test_start_abort_idle;
    wr(cw(1, 1, 0, 16'd4, 8'd2), 7'd3);
    total++;
    if (busy !== 1'b0 || rx_reset !== 1'b0) begin
      bad++;
      $display("FAIL start_abort_idle: busy=%b rx_reset=%b, required 0 0", busy, rx_reset);
    end
    wr(cw(1, 0, 0, 16'd4, 8'd2), 7'd5);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wrong_addr: busy=%b, required 0", busy);
    end
    repeat (5) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_async_reset;
    fr_mode = 0;
    push_ev(EV_RXRST, 0, -1, -1);
    wr(cw(1, 0, 0, 16'd4, 8'd2), 7'd3);
    wait_record(50);
    reset_n = 1'b0;
    #2;
    total++;
    if (record !== 1'b0 || busy !== 1'b0 || step_idx !== 8'd0) begin
      bad++;
      $display("FAIL async_reset: record=%b busy=%b step_idx=%0d, required 0 0 0",
               record, busy, step_idx);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL async_reset_events: pending=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

`ifdef FAST_SQUARE_DRAIN_TIMEOUT_EN
  task automatic test_drain_timeout;
    fr_mode = 2;
    push_ev(EV_RXRST, 0, -1, -1);
    push_ev(EV_REC, RLEN, 4, 0);
    push_ev(EV_STEP, 0, -1, 0);
    wr(cw(1, 0, 0, 16'd4, 8'd2), 7'd3);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    wait_empty(70000, 1'b1);
    total++;
    if (drain_timeout !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL timeout_hit: drain_timeout=%b busy=%b pending=%0d, required 1 0 0",
               drain_timeout, busy, exp_q.size());
      exp_q.delete();
    end
    fr_mode = 0;
    push_ev(EV_RXRST, 0, -1, -1);
    wr(cw(1, 0, 0, 16'd4, 8'd2), 7'd3);
    total++;
    if (drain_timeout !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_clear: drain_timeout=%b busy=%b, required 0 1", drain_timeout, busy);
    end
    wr(cw(0, 1, 0, 16'd4, 8'd2), 7'd3);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
  endtask
`endif

  initial begin
    sbus.serial_addr   = '0;
    sbus.serial_data   = '0;
    sbus.serial_strobe = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_basic();
    test_fifo_toggle();
    test_abort();
    test_continuous();
    test_start_abort_idle();
    test_async_reset();
    test_num_steps_zero();
`ifdef FAST_SQUARE_DRAIN_TIMEOUT_EN
    test_drain_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
